seqdet_param: RTL and testbench
===============================

Name: seqdet_param

Overview:
- Parametrised serial sequence detector, the successor to the fixed 1101 detector.
- Pattern, pattern length and overlap mode are runtime-configurable.
- Accepts one qualified bit per clock and flags every match with a registered pulse.
- Keeps a saturating match counter. Sits after a bit-serial receiver and reports to a status/control block.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..32).
- LEN_W, $clog2(MAX_LEN+1), width of the length field.
- CNT_W, 8, width of the match counter.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- cfg_we  input  1  load cfg_pattern/cfg_len/cfg_overlap this cycle
- cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last
- cfg_len  input  LEN_W  pattern length, legal 1..MAX_LEN
- cfg_overlap  input  1  1 = overlapping matches allowed, 0 = non-overlapping
- cnt_clr  input  1  synchronous clear of match_count
- data_valid  input  1  data_in is qualified this cycle
- data_in  input  1  serial data bit
- found_flag  output  1  one-cycle match pulse, registered
- match_count  output  CNT_W  saturating number of matches
- cfg_err  output  1  one-cycle pulse, illegal config rejected

Behaviour:
- Reset: reset_n is asynchronous and active-low; clock is clock. While reset_n=0 the following hold:
  - found_flag=0, cfg_err=0, match_count=0.
  - History register=0, fill counter=0.
  - Active config = pattern 'b1101 (zero-extended), len=4, overlap=1.
- Deassertion is synchronous to clock.
- History: MAX_LEN-bit shift register, shifted left with data_in in bit 0 on every cycle with data_valid=1. No change when data_valid=0.
- Fill counter: counts accepted bits since the last clear and saturates at MAX_LEN.
- Match condition, evaluated on the accepted bit, must meet all three:
  - data_valid=1;
  - fill (including the current bit) >= len;
  - the new history[len-1:0] equals pattern[len-1:0].
- Latency: found_flag=1 in the cycle after the clock edge that accepted the final pattern bit, for exactly one cycle. Back-to-back matches give consecutive pulses.
- Overlap=1: the fill counter is kept after a match, so suffix/prefix reuse is allowed (e.g. 1101101 matches twice for 1101).
- Overlap=0: after a match the fill counter is cleared to 0. The next match needs len fresh bits.
- match_count:
  - Increments by 1 on each match and saturates at 2^CNT_W-1.
  - cnt_clr=1 sets it to 0; if a match occurs in the same cycle, the result is 0 (clear wins).
- Config load (cfg_we=1):
  - If 1 <= cfg_len <= MAX_LEN: the active config is replaced, history and fill are cleared, and any data_valid bit in that cycle is discarded (no match, no shift).
  - If cfg_len=0 or cfg_len>MAX_LEN: the config is unchanged, cfg_err pulses 1 cycle later, history/fill are unchanged, and the data bit is processed normally against the old config.
- Pattern bits above len-1 are ignored.
- data_valid=0 with data_in toggling has no effect on any state.
- Reset mid-pattern: all partial progress is lost and the default config is restored.
- Implementation: shift-register comparator plus a small control FSM with states IDLE (fill=0), FILLING (0<fill<len) and ARMED (fill>=len).
  - IDLE -> FILLING on the first valid bit.
  - FILLING -> ARMED when fill reaches len.
  - ARMED -> IDLE on a match when overlap=0.
  - Any state -> IDLE on a legal cfg_we.

Test Plan:
- Default config after reset, valid stream 1,1,0,1,1,0,1 -> found_flag pulses after bits 4 and 7; match_count=2.
- Legal cfg_we with pattern='b1101, len=4, overlap=0; stream 1,1,0,1,1,0,1 -> one pulse only (after bit 4); match_count=1.
- Legal cfg_we with pattern='b10101010, len=8, overlap=1; stream of 12 alternating bits starting with 1 -> pulses after bits 8, 10 and 12; data_valid gaps inserted mid-stream give identical results.
- cfg_len=0, then cfg_len=9 with MAX_LEN=8 -> cfg_err pulses twice; the default 1101 pattern is still detected afterwards.
- CNT_W=2, 5 matches -> match_count holds 3; cnt_clr asserted in the same cycle as a match -> match_count=0.
- reset_n pulsed low asynchronously after bits 1,1,0, then bit 1 -> no found_flag; outputs are 0 immediately during reset.

Source files
------------

// File: rtl/seqdet_param.sv
// Runtime-configurable serial pattern detector: compares the newest len accepted bits
// against the active pattern, pulses found_flag on each match and counts matches.
module seqdet_param #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = $clog2(MAX_LEN + 1),
   parameter int CNT_W   = 8
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               cfg_we,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               cnt_clr,
   input  logic               data_valid,
   input  logic               data_in,
   output logic               found_flag,
   output logic [CNT_W-1:0]   match_count,
   output logic               cfg_err
);
   localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);
   localparam logic [MAX_LEN-1:0] DEF_PAT   = MAX_LEN'(4'b1101);
   localparam logic [LEN_W-1:0]   DEF_LEN   = LEN_W'(4);

   typedef enum logic [1:0] {IDLE, FILLING, ARMED} state_t;

   state_t             state, state_nx;
   logic [MAX_LEN-1:0] pat_act;
   logic [LEN_W-1:0]   len_act;
   logic               ovl_act;
   // The incoming bit always completes the compare window, so only MAX_LEN-1 older bits are kept.
   logic [MAX_LEN-2:0] hist;
   logic [MAX_LEN-1:0] hist_nx;
   logic [LEN_W-1:0]   fill, fill_inc, fill_nx;
   logic               cfg_ok, cfg_bad, accept, armed, match;

   function automatic logic [LEN_W-1:0] sat_fill(input logic [LEN_W-1:0] f);
      return (f >= MAX_LEN_L) ? MAX_LEN_L : f + LEN_W'(1);
   endfunction

   function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] l);
      logic [MAX_LEN-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_LEN; i++) m[i] = (LEN_W'(i) < l);
      return m;
   endfunction

   always_comb begin
      cfg_ok   = cfg_we && (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
      cfg_bad  = cfg_we && !cfg_ok;
      accept   = data_valid && !cfg_ok;
      hist_nx  = {hist, data_in};
      fill_inc = sat_fill(fill);
      armed    = (state == ARMED) || (fill_inc == len_act);
      match    = accept && armed &&
                 (((hist_nx ^ pat_act) & len_mask(len_act)) == '0);
      state_nx = state;
      fill_nx  = fill;
      if (cfg_ok) begin
         state_nx = IDLE;
         fill_nx  = '0;
      end else if (accept) begin
         if (match && !ovl_act) begin
            state_nx = IDLE;
            fill_nx  = '0;
         end else begin
            fill_nx  = fill_inc;
            state_nx = armed ? ARMED : FILLING;
         end
      end
   end

   // Registered state, config and outputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         fill        <= '0;
         hist        <= '0;
         pat_act     <= DEF_PAT;
         len_act     <= DEF_LEN;
         ovl_act     <= 1'b1;
         found_flag  <= 1'b0;
         cfg_err     <= 1'b0;
         match_count <= '0;
      end else begin
         state      <= state_nx;
         fill       <= fill_nx;
         found_flag <= match;
         cfg_err    <= cfg_bad;
         if (cfg_ok) begin
            pat_act <= cfg_pattern;
            len_act <= cfg_len;
            ovl_act <= cfg_overlap;
            hist    <= '0;
         end else if (accept) begin
            hist <= hist_nx[MAX_LEN-2:0];
         end
         if (cnt_clr)    match_count <= '0;
         else if (match) match_count <= sat_cnt(match_count);
      end
   end
endmodule

// File: tb/tb_seqdet_param.sv
// Bench for seqdet_param: hand-derived vector tables, multi-cycle corner sequences and
// randomized traffic against a queue-based model, on CNT_W=8 and CNT_W=2 instances.
module tb_seqdet_param;
   localparam int MAX_LEN = 8;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       cfg_we = 1'b0;
   logic [7:0] cfg_pattern = '0;
   logic [3:0] cfg_len = '0;
   logic       cfg_overlap = 1'b0;
   logic       cnt_clr = 1'b0;
   logic       data_valid = 1'b0;
   logic       data_in = 1'b0;
   logic       found8, err8, found2, err2;
   logic [7:0] cnt8;
   logic [1:0] cnt2;
   int         checks = 0;
   int         errors = 0;

   always #5 clock = ~clock;

   seqdet_param #(.MAX_LEN(8), .CNT_W(8)) u8 (
      .clock(clock), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
      .data_valid(data_valid), .data_in(data_in), .found_flag(found8),
      .match_count(cnt8), .cfg_err(err8));

   seqdet_param #(.MAX_LEN(8), .CNT_W(2)) u2 (
      .clock(clock), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
      .data_valid(data_valid), .data_in(data_in), .found_flag(found2),
      .match_count(cnt2), .cfg_err(err2));

   // Reference model: accepted bits since the last clear, newest at the back
   logic [7:0] m_pat;
   int         m_len;
   bit         m_ovl;
   bit         hq[$];
   int         m_cnt8, m_cnt2;
   bit         e_found, e_err;

   task automatic model_reset();
      m_pat = 8'b1101; m_len = 4; m_ovl = 1'b1; hq.delete();
      m_cnt8 = 0; m_cnt2 = 0; e_found = 1'b0; e_err = 1'b0;
   endtask

   task automatic model_step(input logic we, input logic [7:0] pat, input logic [3:0] len,
                             input logic ovl, input logic clr, input logic dv, input logic din);
      bit hit;
      hit = 1'b0;
      e_err = 1'b0;
      if (we && int'(len) >= 1 && int'(len) <= MAX_LEN) begin
         m_pat = pat; m_len = int'(len); m_ovl = ovl; hq.delete();
      end else begin
         e_err = we;
         if (dv) begin
            hq.push_back(din);
            if (hq.size() >= m_len) begin
               hit = 1'b1;
               for (int i = 0; i < m_len; i++)
                  if (hq[hq.size() - 1 - i] != m_pat[i]) hit = 1'b0;
            end
            if (hit && !m_ovl) hq.delete();
            if (hq.size() > 64) void'(hq.pop_front());
         end
      end
      e_found = hit;
      if (clr) begin
         m_cnt8 = 0; m_cnt2 = 0;
      end else if (hit) begin
         if (m_cnt8 < 255) m_cnt8++;
         if (m_cnt2 < 3) m_cnt2++;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cycle(input logic we, input logic [7:0] pat, input logic [3:0] len,
                        input logic ovl, input logic clr, input logic dv, input logic din);
      cfg_we = we; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
      cnt_clr = clr; data_valid = dv; data_in = din;
      model_step(we, pat, len, ovl, clr, dv, din);
      @(posedge clock);
      #1;
   endtask

   task automatic chk_model(input string nm);
      chk({nm, " found8"}, 32'(found8), 32'(e_found));
      chk({nm, " err8"},   32'(err8),   32'(e_err));
      chk({nm, " cnt8"},   32'(cnt8),   32'(m_cnt8));
      chk({nm, " found2"}, 32'(found2), 32'(e_found));
      chk({nm, " err2"},   32'(err2),   32'(e_err));
      chk({nm, " cnt2"},   32'(cnt2),   32'(m_cnt2));
   endtask

   task automatic bit_in(input logic din);
      cycle(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, din);
   endtask

   typedef struct {
      bit we; bit [7:0] pat; bit [3:0] len; bit ovl; bit clr; bit dv; bit din;
      bit x_found; bit x_err; bit [7:0] x_cnt;
   } vec_t;
   vec_t tab[$];

   task automatic add(input bit we, input bit [7:0] pat, input bit [3:0] len, input bit ovl,
                      input bit clr, input bit dv, input bit din,
                      input bit xf, input bit xe, input bit [7:0] xc);
      vec_t v;
      v.we = we; v.pat = pat; v.len = len; v.ovl = ovl; v.clr = clr; v.dv = dv; v.din = din;
      v.x_found = xf; v.x_err = xe; v.x_cnt = xc;
      tab.push_back(v);
   endtask

   task automatic b(input bit din, input bit xf, input bit [7:0] xc);
      add(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, din, xf, 1'b0, xc);
   endtask

   task automatic gap(input bit din, input bit [7:0] xc);
      add(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, din, 1'b0, 1'b0, xc);
   endtask

   task automatic run_tab(input string nm);
      foreach (tab[i]) begin
         cycle(tab[i].we, tab[i].pat, tab[i].len, tab[i].ovl, tab[i].clr, tab[i].dv, tab[i].din);
         chk($sformatf("%s[%0d] found8", nm, i), 32'(found8), 32'(tab[i].x_found));
         chk($sformatf("%s[%0d] err8", nm, i),   32'(err8),   32'(tab[i].x_err));
         chk($sformatf("%s[%0d] cnt8", nm, i),   32'(cnt8),   32'(tab[i].x_cnt));
         chk($sformatf("%s[%0d] found2", nm, i), 32'(found2), 32'(tab[i].x_found));
         chk($sformatf("%s[%0d] cnt2", nm, i),   32'(cnt2),   32'(m_cnt2));
      end
      tab.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      #2;
      chk("reset found8", 32'(found8), 32'd0);
      chk("reset cnt8",   32'(cnt8),   32'd0);
      chk("reset err8",   32'(err8),   32'd0);
      #10 reset_n = 1'b1;

      // Default 1101 overlapping, then non-overlapping, then an 8-bit pattern with gaps
      b(1,0,0); b(1,0,0); b(0,0,0); b(1,1,1); b(1,0,1); b(0,0,1); b(1,1,2);
      gap(1, 2);
      add(1, 8'b1101, 4'd4, 0, 0, 1, 1, 0, 0, 2);
      add(0, 8'h00, 4'd0, 0, 1, 0, 0, 0, 0, 0);
      b(1,0,0); b(1,0,0); b(0,0,0); b(1,1,1); b(1,0,1); b(0,0,1); b(1,0,1);
      add(1, 8'hAA, 4'd8, 1, 1, 0, 0, 0, 0, 0);
      b(1,0,0); b(0,0,0); b(1,0,0); gap(0,0); gap(1,0);
      b(0,0,0); b(1,0,0); b(0,0,0); b(1,0,0); b(0,1,1);
      b(1,0,1); gap(0,1); b(0,1,2); b(1,0,2); b(0,1,3);
      run_tab("cfgseq");

      // Asynchronous reset mid-pattern clears progress and restores the default config
      bit_in(1); chk_model("pre1"); bit_in(1); chk_model("pre2"); bit_in(0); chk_model("pre3");
      cycle(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      chk("inrst found8", 32'(found8), 32'd0);
      chk("inrst cnt8",   32'(cnt8),   32'd0);
      chk("inrst cnt2",   32'(cnt2),   32'd0);
      chk("inrst err8",   32'(err8),   32'd0);
      model_reset();
      #2 reset_n = 1'b1;
      bit_in(1); chk_model("post1");
      chk("post1 nofound", 32'(found8), 32'd0);
      bit_in(1); chk_model("post2"); bit_in(0); chk_model("post3");
      bit_in(1); chk_model("post4");
      chk("post4 default", 32'(found8), 32'd1);

      // Illegal lengths are rejected and the old config keeps matching
      add(1, 8'hFF, 4'd15, 0, 0, 0, 0, 0, 1, 1);
      add(1, 8'h00, 4'd0,  0, 0, 1, 1, 0, 1, 1);
      add(1, 8'h00, 4'd9,  0, 0, 1, 1, 0, 1, 1);
      b(0,0,1); b(1,1,2);
      run_tab("badcfg");

      // Counter saturation on the 2-bit instance, then clear beating a match
      cycle(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0); chk_model("clr");
      bit_in(1); bit_in(1); bit_in(0); bit_in(1); chk_model("sat m1");
      for (int k = 0; k < 4; k++) begin
         bit_in(1); bit_in(0); bit_in(1); chk_model($sformatf("sat m%0d", k + 2));
      end
      chk("sat cnt2", 32'(cnt2), 32'd3);
      chk("sat cnt8", 32'(cnt8), 32'd5);
      bit_in(1); bit_in(0);
      cycle(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
      chk_model("clrwin");
      chk("clrwin found8", 32'(found8), 32'd1);
      chk("clrwin cnt8",   32'(cnt8),   32'd0);
      chk("clrwin cnt2",   32'(cnt2),   32'd0);

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         logic       r_we, r_ovl, r_clr, r_dv, r_din;
         logic [7:0] r_pat;
         logic [3:0] r_len;
         r_we  = ($urandom_range(0, 15) == 0);
         r_pat = 8'($urandom);
         r_len = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
         r_ovl = 1'($urandom_range(0, 1));
         r_clr = ($urandom_range(0, 31) == 0);
         r_dv  = ($urandom_range(0, 3) != 0);
         r_din = 1'($urandom_range(0, 1));
         cycle(r_we, r_pat, r_len, r_ovl, r_clr, r_dv, r_din);
         chk_model($sformatf("rand%0d", n));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
